// File: rtl/seq_detect_param.sv
// seq_detect_param: Moore serial sequence detector with a run-time pattern.
// The last LEN enabled samples of x are compared against `pattern`
// (pattern[LEN-1] is the oldest bit). Overlapping or non-overlapping
// detection is selected by `overlap`.
// Optional feature macro: SEQ_DETECT_CNT_EN adds the match_cnt port and a
// CNT_W-bit saturating match counter.
module seq_detect_param #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr,
    input  logic           x,
    input  logic [LEN-1:0] pattern,
    input  logic           overlap,
    output logic           y
`ifdef SEQ_DETECT_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int FW = $clog2(LEN + 1);

    // Out-of-range parameters disable detection rather than produce garbage.
    localparam bit CFG_OK = (LEN >= 2) && (LEN <= 16) && (CNT_W >= 1) && (CNT_W <= 32);

    logic [LEN-1:0] hist;
    logic [LEN-1:0] hist_n;
    logic [FW-1:0]  fill;
    logic [FW-1:0]  fill_n;
    logic [FW-1:0]  fill_next;
    logic           hit;
    logic           match;

    // Candidate window and fill level for an enabled edge, plus the match decision.
    always_comb begin
        hist_n = {hist[LEN-2:0], x};
        fill_n = (fill == FW'(LEN)) ? fill : fill + FW'(1);
        match  = CFG_OK && (fill_n == FW'(LEN)) && (hist_n == pattern);
    end

    // Non-overlapping mode restarts the fill count after each match.
    always_comb begin
        fill_next = fill_n;
        if (match && !overlap) begin
            fill_next = '0;
        end
    end

    // History, fill level and registered match flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
            hit  <= 1'b0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            hit  <= 1'b0;
        end else if (en) begin
            hist <= hist_n;
            fill <= fill_next;
            hit  <= match;
        end
    end

    assign y = hit;

`ifdef SEQ_DETECT_CNT_EN
    // Saturating count of match events; holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (clr) begin
            match_cnt <= '0;
        end else if (en && match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: two instances (LEN=3/CNT_W=2 and
// LEN=5/CNT_W=8) share the control inputs and are checked against a
// window-of-recent-bits reference model, with directed steps followed by
// randomized traffic. Counter checks are present when SEQ_DETECT_CNT_EN is set.
module tb_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       x;
    logic       overlap;
    logic [2:0] p3;
    logic [4:0] p5;
    logic       y3;
    logic       y5;
    logic [1:0] cnt3;
    logic [7:0] cnt5;

    int checks = 0;
    int errors = 0;

    // reference model state, index 0 -> LEN=3 instance, 1 -> LEN=5 instance
    int lenm [2] = '{3, 5};
    int cmax [2] = '{3, 255};
    bit recent [2][$];
    int fresh [2];
    int ym [2];
    int cm [2];

    seq_detect_param #(.LEN(3), .CNT_W(2)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
        .pattern(p3), .overlap(overlap), .y(y3)
`ifdef SEQ_DETECT_CNT_EN
        , .match_cnt(cnt3)
`endif
    );

    seq_detect_param #(.LEN(5), .CNT_W(8)) u5 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x),
        .pattern(p5), .overlap(overlap), .y(y5)
`ifdef SEQ_DETECT_CNT_EN
        , .match_cnt(cnt5)
`endif
    );

`ifndef SEQ_DETECT_CNT_EN
    assign cnt3 = '0;
    assign cnt5 = '0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            recent[k].delete();
            fresh[k] = 0;
            ym[k] = 0;
            cm[k] = 0;
        end
    endtask

    // Pattern value as an integer with the oldest bit most significant.
    function automatic int window_value(input int k);
        int v = 0;
        for (int i = 0; i < recent[k].size(); i++) v = v * 2 + int'(recent[k][i]);
        return v;
    endfunction

    task automatic model_step(input bit e, input bit c, input bit xb, input bit ov);
        int pat;
        bit m;
        if (c) begin
            model_clear();
            return;
        end
        if (!e) return;
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? int'(p3) : int'(p5);
            recent[k].push_back(xb);
            if (recent[k].size() > lenm[k]) void'(recent[k].pop_front());
            if (fresh[k] < lenm[k]) fresh[k]++;
            m = (fresh[k] == lenm[k]) && (window_value(k) == pat);
            ym[k] = m ? 1 : 0;
            if (m && cm[k] < cmax[k]) cm[k]++;
            if (m && !ov) fresh[k] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y3"}, int'(y3), ym[0]);
        check({tag, ".y5"}, int'(y5), ym[1]);
`ifdef SEQ_DETECT_CNT_EN
        check({tag, ".cnt3"}, int'(cnt3), cm[0]);
        check({tag, ".cnt5"}, int'(cnt5), cm[1]);
`endif
    endtask

    // One clock: drive inputs, take the edge, update model, check 1 ns later.
    // ey >= 0 additionally checks u3's y against a hand-written value.
    task automatic cycle(input bit e, input bit c, input bit xb, input bit ov,
                         input string tag, input int ey = -1);
        en = e;
        clr = c;
        x = xb;
        overlap = ov;
        @(posedge clk);
        model_step(e, c, xb, ov);
        #1;
        check_all(tag);
        if (ey >= 0) check({tag, ".tp"}, int'(y3), ey);
    endtask

    // Pulse rst_n between clock edges and check it acts without an edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        check_all(tag);
        check({tag, ".y3_now"}, int'(y3), 0);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bit e;
        bit c;
        bit b;
        bit ov;
        rst_n = 1'b0;
        en = 1'b0;
        clr = 1'b0;
        x = 1'b0;
        overlap = 1'b1;
        p3 = 3'b111;
        p5 = 5'b10110;
        model_clear();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // pattern 111, overlapping
        cycle(1, 0, 1, 1, "ov111_1", 0);
        cycle(1, 0, 1, 1, "ov111_2", 0);
        cycle(1, 0, 1, 1, "ov111_3", 1);
        cycle(1, 0, 1, 1, "ov111_4", 1);
        cycle(1, 0, 0, 1, "ov111_5", 0);

        // same stream non-overlapping
        cycle(0, 1, 0, 0, "clr_a", 0);
        cycle(1, 0, 1, 0, "no111_1", 0);
        cycle(1, 0, 1, 0, "no111_2", 0);
        cycle(1, 0, 1, 0, "no111_3", 1);
        cycle(1, 0, 1, 0, "no111_4", 0);
        cycle(1, 0, 0, 0, "no111_5", 0);
`ifdef SEQ_DETECT_CNT_EN
        check("no111_cnt", int'(cnt3), 1);
`endif

        // pattern 101, overlapping then non-overlapping
        p3 = 3'b101;
        cycle(0, 1, 0, 1, "clr_b", 0);
        cycle(1, 0, 1, 1, "ov101_1", 0);
        cycle(1, 0, 0, 1, "ov101_2", 0);
        cycle(1, 0, 1, 1, "ov101_3", 1);
        cycle(1, 0, 0, 1, "ov101_4", 0);
        cycle(1, 0, 1, 1, "ov101_5", 1);
`ifdef SEQ_DETECT_CNT_EN
        check("ov101_cnt", int'(cnt3), 2);
`endif
        cycle(0, 1, 0, 0, "clr_c", 0);
        cycle(1, 0, 1, 0, "no101_1", 0);
        cycle(1, 0, 0, 0, "no101_2", 0);
        cycle(1, 0, 1, 0, "no101_3", 1);
        cycle(1, 0, 0, 0, "no101_4", 0);
        cycle(1, 0, 1, 0, "no101_5", 0);
`ifdef SEQ_DETECT_CNT_EN
        check("no101_cnt", int'(cnt3), 1);
`endif

        // fill gate: pattern 000 straight after reset
        async_reset("rst_fill");
        p3 = 3'b000;
        cycle(1, 0, 0, 1, "fill_1", 0);
        cycle(1, 0, 0, 1, "fill_2", 0);
        cycle(1, 0, 0, 1, "fill_3", 1);

        // enable gaps between samples; y holds while en is low
        p3 = 3'b111;
        cycle(0, 1, 0, 1, "clr_d", 0);
        cycle(1, 0, 1, 1, "en_1", 0);
        cycle(0, 0, 0, 1, "en_gap1", 0);
        cycle(1, 0, 1, 1, "en_2", 0);
        cycle(0, 0, 0, 1, "en_gap2", 0);
        cycle(1, 0, 1, 1, "en_3", 1);
        cycle(0, 0, 0, 1, "en_hold1", 1);
        cycle(0, 0, 1, 1, "en_hold2", 1);
        cycle(1, 1, 1, 1, "en_clr", 0);
`ifdef SEQ_DETECT_CNT_EN
        check("en_clr_cnt", int'(cnt3), 0);
`endif

        // saturation of the 2-bit counter, then async reset mid-run
        for (int i = 0; i < 7; i++) cycle(1, 0, 1, 1, "sat", (i >= 2) ? 1 : 0);
`ifdef SEQ_DETECT_CNT_EN
        check("sat_cnt3", int'(cnt3), 3);
        check("sat_cnt5", int'(cnt5), 0);
`endif
        cycle(1, 0, 1, 1, "sat_more", 1);
        async_reset("rst_mid");
        p3 = 3'b000;
        cycle(1, 0, 0, 1, "restart_1", 0);
        cycle(1, 0, 0, 1, "restart_2", 0);
        cycle(1, 0, 0, 1, "restart_3", 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 39) == 0);
            b = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) overlap = $urandom_range(0, 1);
            ov = overlap;
            if ($urandom_range(0, 49) == 0) p3 = 3'($urandom);
            if ($urandom_range(0, 49) == 0) p5 = 5'($urandom);
            cycle(e, c, b, ov, "rand");
            if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
